// File: rtl/video_pattern_gen.sv
// Video timing generator with a double-buffered four-slot single-pixel marker overlay.
// Shadow marker slots and the background colour are promoted to the active set at each frame boundary.
module video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Enable,
    input  logic [23:0] BgColor,
    input  logic        MarkWr,
    input  logic [1:0]  MarkIdx,
    input  logic        MarkEn,
    input  logic [10:0] MarkX,
    input  logic [9:0]  MarkY,
    input  logic [23:0] MarkRGB,
    output logic        HSync,
    output logic        VSync,
    output logic        VDE,
    output logic [23:0] RGB,
    output logic        FrameStart,
    output logic [15:0] FrameCount
);

    localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYN_S = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYN_E = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST  = 11'(HTOTAL - 1);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYN_S = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYN_E = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST  = 10'(VTOTAL - 1);

    typedef struct packed {
        logic        en;
        logic [10:0] x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } slot_t;

    slot_t       shadow_q [4];
    slot_t       active_q [4];
    logic [23:0] bg_q;
    logic [10:0] hcnt;
    logic [9:0]  vcnt;

    logic        h_last;
    logic        v_last;
    logic        boundary;
    logic        in_active;
    logic        in_hsync;
    logic        in_vsync;
    logic [23:0] pix_rgb;

    always_comb begin
        h_last    = (hcnt == H_LAST);
        v_last    = (vcnt == V_LAST);
        boundary  = Enable && h_last && v_last;
        in_active = (hcnt < H_ACT) && (vcnt < V_ACT);
        in_hsync  = (hcnt >= H_SYN_S) && (hcnt < H_SYN_E);
        in_vsync  = (vcnt >= V_SYN_S) && (vcnt < V_SYN_E);
    end

    // Walk from the highest slot down so the lowest matching index wins.
    always_comb begin
        pix_rgb = bg_q;
        for (int i = 3; i >= 0; i--) begin
            if (active_q[i].en && active_q[i].x == hcnt && active_q[i].y == vcnt &&
                active_q[i].x < H_ACT && active_q[i].y < V_ACT) begin
                pix_rgb = active_q[i].rgb;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!Enable) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 11'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
        end else if (MarkWr) begin
            shadow_q[MarkIdx] <= {MarkEn, MarkX, MarkY, MarkRGB};
        end
    end

    // Active set reads the pre-write shadow, so a write on the boundary waits a frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) active_q[i] <= '0;
            bg_q <= '0;
        end else if (!Enable || boundary) begin
            active_q <= shadow_q;
            bg_q     <= BgColor;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            HSync      <= 1'b0;
            VSync      <= 1'b0;
            VDE        <= 1'b0;
            RGB        <= '0;
            FrameStart <= 1'b0;
        end else if (!Enable) begin
            HSync      <= 1'b0;
            VSync      <= 1'b0;
            VDE        <= 1'b0;
            RGB        <= '0;
            FrameStart <= 1'b0;
        end else begin
            HSync      <= in_hsync;
            VSync      <= in_vsync;
            VDE        <= in_active;
            RGB        <= in_active ? pix_rgb : 24'h000000;
            FrameStart <= (hcnt == '0) && (vcnt == '0);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FrameCount <= '0;
        end else if (boundary) begin
            FrameCount <= FrameCount + 16'd1;
        end
    end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 1280; H_FP 110; H_SYNC 40; H_BP 220; V_ACTIVE 720; V_FP 5; V_SYNC 5; V_BP 20. HTOTAL and VTOTAL SHALL be the sums of the four respective values: 1650 and 750.
REQ-002 Ports SHALL be as follows. There SHALL be one clock, and reset SHALL be asynchronous and active-low.
- CLK      in   1   pixel clock
- RST_N    in   1   asynchronous active-low reset
- Enable   in   1   run generator
- BgColor  in   24  background RGB, sampled at frame boundary
- MarkWr   in   1   marker shadow write strobe
- MarkIdx  in   2   marker slot index
- MarkEn   in   1   slot enable
- MarkX    in   11  marker column
- MarkY    in   10  marker row
- MarkRGB  in   24  marker colour
- HSync    out  1   horizontal sync, active-high
- VSync    out  1   vertical sync, active-high
- VDE      out  1   active-video enable
- RGB      out  24  pixel data
- FrameStart out 1  one-cycle pulse on the first pixel of each frame
- FrameCount out 16 completed-frame counter

Function
REQ-003 hcnt SHALL count 0..HTOTAL-1 and wrap to 0.
REQ-004 vcnt SHALL increment when hcnt wraps, counting 0..VTOTAL-1 and then wrapping to 0.
REQ-005 Active region SHALL be hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-006 The hsync region SHALL be hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [1390,1430).
REQ-007 The vsync region SHALL be vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [725,730), covering whole lines.
REQ-008 All outputs SHALL be registered, with a latency of exactly 1 cycle from counter state to output.
REQ-009 VDE SHALL be 1 only in the active region.
REQ-010 RGB SHALL be 24'h000000 whenever VDE is 0.
REQ-011 In the active region, RGB SHALL be MarkRGB of the lowest-index enabled active slot with X==hcnt and Y==vcnt; otherwise RGB SHALL be the active BgColor.
REQ-012 Each of the 4 marker slots SHALL have a shadow copy and an active copy.
REQ-013 A MarkWr pulse SHALL write {MarkEn,MarkX,MarkY,MarkRGB} into shadow slot MarkIdx.
REQ-014 Boundary cycle SHALL be defined as hcnt==HTOTAL-1 and vcnt==VTOTAL-1.
REQ-015 On a boundary cycle, all shadow slots SHALL be copied to the active copies and BgColor SHALL be latched.
REQ-016 A MarkWr on the boundary cycle SHALL land in shadow only and SHALL take effect at the following boundary.
REQ-017 Multiple MarkWr pulses to one slot within a frame SHALL result in the last write winning.
REQ-018 A marker with X>=H_ACTIVE or Y>=V_ACTIVE SHALL never be drawn.
REQ-019 FrameStart SHALL be 1 on the output cycle that reflects hcnt=0, vcnt=0.
REQ-020 FrameCount SHALL increment by 1 on each boundary cycle while Enable is high, wrapping from 16'hFFFF to 0.
REQ-021 While Enable is 0, counters SHALL hold at 0.
REQ-022 While Enable is 0, HSync, VSync, VDE, RGB and FrameStart SHALL be 0 from the next cycle.
REQ-023 While Enable is 0, shadow slots and BgColor SHALL be copied to the active copies every cycle.
REQ-024 While Enable is 0, FrameCount SHALL hold.
REQ-025 On Enable 0->1, the first cycle SHALL have hcnt=0 and vcnt=0, and FrameStart SHALL be output 1 cycle later.
REQ-026 Enable falling mid-frame SHALL abort the frame immediately, with no FrameCount increment.

Reset
REQ-027 While RST_N=0, hcnt, vcnt, HSync, VSync, VDE, RGB, FrameStart and FrameCount SHALL be 0.
REQ-028 While RST_N=0, all shadow and active slots SHALL have En=0, X=0, Y=0 and RGB=0, and the latched BgColor SHALL be 0.
REQ-029 Reset assertion SHALL take effect asynchronously; deassertion SHALL be sampled on the CLK rising edge.
REQ-030 Reset asserted mid-frame SHALL abort the frame, and after release with Enable=1 the generator SHALL restart at hcnt=0, vcnt=0.

Verification
REQ-031 Timing check: reset, Enable=1, BgColor=24'h102030, run 2 frames. Required response:
- VDE high for 1280 cycles per line on 720 lines.
- HSync high for 40 cycles starting 110 cycles after VDE falls.
- VSync high for 5 full lines starting at line 725.
- Period of 1650x750=1237500 cycles.
- FrameCount=2.
REQ-032 Marker: with Enable=0, write slot1 {En=1,X=84,Y=605,RGB=24'h3A7500}, then Enable=1. Required response: RGB=24'h3A7500 exactly at pixel (84,605), and BgColor on neighbours (83,605), (85,605) and (84,604).
REQ-033 Double buffer: mid-frame N, write slot0 {En=1,X=10,Y=10,RGB=24'hFFFFFF}. Required response: frame N pixel (10,10)=BgColor; frame N+1 pixel (10,10)=24'hFFFFFF.
REQ-034 Priority and boundary: slot0 and slot2 both at (0,0) with RGB=24'hAA0000 and 24'h00BB00; a write on the boundary cycle sets slot0 En=0. Required response:
- Next frame (0,0)=24'hAA0000.
- Frame after that (0,0)=24'h00BB00.
- A slot at X=1280 is never drawn.
REQ-035 Abort: drop Enable at line 300 pixel 500, raise it 10 cycles later. Required response: outputs 0 during the gap, FrameCount unchanged, FrameStart pulse 1 cycle after re-enable. The same scenario SHALL be repeated with RST_N pulsed instead, with the same outcome except FrameCount=0.
REQ-036 FrameCount wrap: force 1 frame after FrameCount=16'hFFFF. Required response: FrameCount=0.
